// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : fetch/issue sequencer with stall, single-level loop and HALT
// Rev 1.0
// ============================================================================
module pc_sequencer #(
  parameter int              ADDR_W     = 5,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [3:0]      OPC_HALT   = 4'hF,
  parameter logic [3:0]      OPC_LOOP   = 4'hE
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  input  logic [15:0]       instr_in,
  output logic [ADDR_W-1:0] pc,
  output logic              issue,
  output logic              busy,
  output logic              done,
  output logic              loop_active,
  output logic [15:0]       retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       retired_q, retired_d;
  logic              loop_active_q, loop_active_d;
  logic [3:0]        loop_cnt_q, loop_cnt_d;

  logic [3:0]        op;
  logic [3:0]        loop_n;
  logic [ADDR_W-1:0] target;
  logic              in_exec, is_halt, is_loop, retire, wrap;

  assign op     = instr_in[15:12];
  assign loop_n = instr_in[11:8];
  assign target = ADDR_W'(instr_in[7:0]);

  assign in_exec = (state_q == S_EXEC);
  assign is_halt = in_exec && (op == OPC_HALT);
  assign is_loop = in_exec && (op == OPC_LOOP);
  assign issue   = in_exec && (op != OPC_HALT) && (op != OPC_LOOP);
  assign retire  = issue && !stall && !abort;
  assign wrap    = retire && (pc_q == PC_LAST);

  assign busy        = (state_q != S_IDLE);
  assign done        = !abort && (is_halt || wrap);
  assign pc          = pc_q;
  assign loop_active = loop_active_q;
  assign retired     = retired_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    retired_d     = retired_q;
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d          = START_ADDR;
          retired_d     = '0;
          loop_active_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt) begin
          state_d = S_IDLE;
        end else if (is_loop) begin
          // Control ops never stall: they only redirect the PC.
          state_d = S_FETCH;
          if (!loop_active_q) begin
            if (loop_n == 4'd0) begin
              pc_d = pc_q + ADDR_W'(1);
            end else begin
              loop_cnt_d    = loop_n - 4'd1;
              loop_active_d = 1'b1;
              pc_d          = target;
            end
          end else if (loop_cnt_q != 4'd0) begin
            loop_cnt_d = loop_cnt_q - 4'd1;
            pc_d       = target;
          end else begin
            loop_active_d = 1'b0;
            pc_d          = pc_q + ADDR_W'(1);
          end
        end else if (!stall) begin
          pc_d      = pc_q + ADDR_W'(1);
          retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
          state_d   = wrap ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything decided above, leaving pc/retired untouched.
    if (abort) begin
      state_d       = S_IDLE;
      pc_d          = pc_q;
      retired_d     = retired_q;
      loop_active_d = 1'b0;
      loop_cnt_d    = loop_cnt_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= START_ADDR;
      retired_q     <= '0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      retired_q     <= retired_d;
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed scoreboard bench for pc_sequencer
// Rev 1.0
// ============================================================================
module tb_pc_sequencer;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        stall;
  logic [15:0] instr_in;
  logic [4:0]  pc;
  logic        issue;
  logic        busy;
  logic        done;
  logic        loop_active;
  logic [15:0] retired;

  pc_sequencer dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .stall       (stall),
    .instr_in    (instr_in),
    .pc          (pc),
    .issue       (issue),
    .busy        (busy),
    .done        (done),
    .loop_active (loop_active),
    .retired     (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle-latency instruction memory.
  logic [15:0] mem [32];
  always @(posedge clock) instr_in <= mem[pc];

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int rel;
    int pca;
    bit la;
  } exp_t;
  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int t0;
  int done_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int rel, input int pca, input bit la);
    exp_t e;
    e.rel = rel; e.pca = pca; e.la = la;
    exp_q.push_back(e);
  endtask

  task automatic load_linear();
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'hF000;
  endtask

  task automatic load_loop();
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hE200; mem[3] = 16'hF000;
  endtask

  // Starts the program and monitors retires against the scoreboard.
  // rel counts cycles after the start-sampling edge (FETCH of first instr = 1).
  task automatic run_prog(input int st_s, input int st_n, input int ab_at,
                          input int max_cyc, output int d_rel);
    int   rel;
    bit   fin;
    exp_t e;
    logic [15:0] last_ret;
    logic [4:0]  last_pc;
    d_rel = -1;
    fin   = 1'b0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    t0 = edge_cnt;
    last_ret = retired;
    last_pc  = pc;
    for (int k = 0; k < max_cyc && !fin; k++) begin
      rel   = edge_cnt - t0 + 1;
      stall = (rel >= st_s) && (rel < st_s + st_n);
      abort = (rel == ab_at);
      @(negedge clock);
      if (stall) begin
        chk("stall_issue", {31'd0, issue}, 32'd1);
        chk("stall_pc_hold", {27'd0, pc}, {27'd0, last_pc});
        chk("stall_ret_hold", {16'd0, retired}, {16'd0, last_ret});
      end
      if (issue && !stall && !abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_retire", rel, -1);
        end else begin
          e = exp_q.pop_front();
          chk("retire_cycle", rel, e.rel);
          chk("retire_pc", {27'd0, pc}, e.pca);
          chk("retire_loop_active", {31'd0, loop_active}, {31'd0, e.la});
        end
      end
      if (done) d_rel = rel;
      if (done || abort) fin = 1'b1;
      last_ret = retired;
      last_pc  = pc;
      @(posedge clock); #1;
    end
    stall = 1'b0;
    abort = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    load_linear();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", {27'd0, pc}, 0);
    chk("rst_issue", {31'd0, issue}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_loop_active", {31'd0, loop_active}, 0);
    chk("rst_retired", {16'd0, retired}, 0);
    @(negedge clock) rst_n = 1'b1;

    // Linear program
    push(2, 0, 0); push(4, 1, 0); push(6, 2, 0); push(8, 3, 0);
    run_prog(-10, 0, -1, 40, done_rel);
    chk("lin_done_cycle", done_rel, 10);
    chk("lin_retired", {16'd0, retired}, 4);
    chk("lin_pc", {27'd0, pc}, 4);
    chk("lin_idle", {31'd0, busy}, 0);
    chk("lin_done_clear", {31'd0, done}, 0);

    // Three-cycle stall on address 1
    push(2, 0, 0); push(7, 1, 0); push(9, 2, 0); push(11, 3, 0);
    run_prog(4, 3, -1, 40, done_rel);
    chk("stall_done_cycle", done_rel, 13);
    chk("stall_retired", {16'd0, retired}, 4);

    // Loop: body (0,1) runs three times
    load_loop();
    push(2, 0, 0); push(4, 1, 0); push(8, 0, 1); push(10, 1, 1);
    push(14, 0, 1); push(16, 1, 1);
    run_prog(-10, 0, -1, 60, done_rel);
    chk("loop_done_cycle", done_rel, 20);
    chk("loop_retired", {16'd0, retired}, 6);
    chk("loop_pc", {27'd0, pc}, 3);
    chk("loop_active_end", {31'd0, loop_active}, 0);

    // 32-word program, LOOP N=0 at address 5, no HALT: wraps
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5] = 16'hE000;
    for (int a = 0; a < 32; a++) if (a != 5) push(2 * a + 2, a, 0);
    run_prog(-10, 0, -1, 100, done_rel);
    chk("wrap_done_cycle", done_rel, 64);
    chk("wrap_pc", {27'd0, pc}, 0);
    chk("wrap_retired", {16'd0, retired}, 31);
    chk("wrap_idle", {31'd0, busy}, 0);

    // Abort mid-stall inside a loop
    load_loop();
    push(2, 0, 0); push(4, 1, 0);
    run_prog(8, 3, 9, 40, done_rel);
    chk("abort_no_done", done_rel, -1);
    chk("abort_idle", {31'd0, busy}, 0);
    chk("abort_loop_clr", {31'd0, loop_active}, 0);
    chk("abort_pc_hold", {27'd0, pc}, 0);
    chk("abort_ret_hold", {16'd0, retired}, 2);

    // Asynchronous reset mid-loop
    push(2, 0, 0); push(4, 1, 0); push(8, 0, 1);
    run_prog(-10, 0, -1, 9, done_rel);
    chk("pre_rst_loop_active", {31'd0, loop_active}, 1);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", {27'd0, pc}, 0);
    chk("arst_issue", {31'd0, issue}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_loop_active", {31'd0, loop_active}, 0);
    chk("arst_retired", {16'd0, retired}, 0);
    @(negedge clock) rst_n = 1'b1;

    // Restart after reset runs from START_ADDR
    load_linear();
    push(2, 0, 0); push(4, 1, 0); push(6, 2, 0); push(8, 3, 0);
    run_prog(-10, 0, -1, 40, done_rel);
    chk("restart_done_cycle", done_rel, 10);
    chk("restart_retired", {16'd0, retired}, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
